alu_arbiter: RTL and testbench

Round-robin arbiter that shares one combinational 32-bit `alu` between two requesters, such as the issue stage and the branch-resolution unit. Each requester presents operands and a 7-bit `alu_ops` code over a valid/ready handshake. The arbiter grants at most one requester per cycle and drives the shared ALU. It captures the ALU result at the clock edge and returns it through a per-requester 2-entry response FIFO with its own valid/ready handshake.

---
 rtl/alu_arbiter.sv | 150 +++++++++++++++
 tb/tb_alu_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin share of one combinational ALU between two requesters, results returned via per-requester 2-deep FIFOs.
// Latency: request accepted at edge N -> result visible on rspN_* in cycle N+1 (one registered stage).
// Backpressure: a requester whose FIFO is full (and not popping this cycle) is not granted; the other is unaffected.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   reqN_valid/ready/a/b/ops requester N operation handshake (ready = grant, combinational)
//   rspN_valid/ready/data    requester N result handshake (data = FIFO head)
//   alu_a/alu_b/alu_ops      shared ALU operands (all zero when nothing is granted)
//   alu_out                  shared ALU result, captured into the granted requester's FIFO

// 2-entry response FIFO with 1-bit pointers and a 2-bit occupancy count.
// Latency: pushed data is visible at the head the cycle after the push (when empty before).
// Backpressure: exposes count so the producer side decides eligibility; pop only when valid.
module alu_arbiter_fifo #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop_ready,
    output logic         valid,
    output logic [1:0]   count,
    output logic [W-1:0] head
);
    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic         pop;

    assign valid = (count != 2'd0);
    assign pop   = valid && pop_ready;
    assign head  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Storage is intentionally not reset; the head is only meaningful while valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end
endmodule

module alu_arbiter #(
    parameter int DATA_W = 32,
    parameter int OPS_W  = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [OPS_W-1:0]  req0_ops,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [DATA_W-1:0] rsp0_data,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [OPS_W-1:0]  req1_ops,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp1_data,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OPS_W-1:0]  alu_ops,
    input  logic [DATA_W-1:0] alu_out
);
    logic [1:0] count0;
    logic [1:0] count1;
    logic       elig0;
    logic       elig1;
    logic       grant0;
    logic       grant1;
    // Index of the requester granted most recently; 1 after reset so requester 0 wins the first conflict.
    logic       last_grant;

    // A full FIFO can still accept when its consumer pops in the same cycle.
    assign elig0 = !rst && req0_valid && ((count0 != 2'd2) || rsp0_ready);
    assign elig1 = !rst && req1_valid && ((count1 != 2'd2) || rsp1_ready);

    assign grant0 = elig0 && (!elig1 ||  last_grant);
    assign grant1 = elig1 && (!elig0 || !last_grant);

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    always_comb begin
        alu_a   = '0;
        alu_b   = '0;
        alu_ops = '0;
        if (grant0) begin
            alu_a   = req0_a;
            alu_b   = req0_b;
            alu_ops = req0_ops;
        end else if (grant1) begin
            alu_a   = req1_a;
            alu_b   = req1_b;
            alu_ops = req1_ops;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
        end else if (grant0) begin
            last_grant <= 1'b0;
        end else if (grant1) begin
            last_grant <= 1'b1;
        end
    end

    alu_arbiter_fifo #(.W(DATA_W)) u_rsp0_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (grant0),
        .push_data (alu_out),
        .pop_ready (rsp0_ready),
        .valid     (rsp0_valid),
        .count     (count0),
        .head      (rsp0_data)
    );

    alu_arbiter_fifo #(.W(DATA_W)) u_rsp1_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (grant1),
        .push_data (alu_out),
        .pop_ready (rsp1_ready),
        .valid     (rsp1_valid),
        .count     (count1),
        .head      (rsp1_data)
    );
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus randomized traffic against a queue-based reference.
// Latency: results expected one cycle after the modelled grant.
// Backpressure: randomized rspN_ready exercises full-FIFO stalls and pop+push on full.
module tb_alu_arbiter;
    localparam int DATA_W = 32;
    localparam int OPS_W  = 7;

    localparam logic [6:0] ADD_OP = 7'd1;
    localparam logic [6:0] SUB_OP = 7'd2;
    localparam logic [6:0] AND_OP = 7'd3;
    localparam logic [6:0] OR_OP  = 7'd4;
    localparam logic [6:0] XOR_OP = 7'd5;
    localparam logic [6:0] BEQ_OP = 7'd6;
    localparam logic [6:0] BNE_OP = 7'd7;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req0_valid = 1'b0, req1_valid = 1'b0;
    logic              req0_ready, req1_ready;
    logic [DATA_W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [OPS_W-1:0]  req0_ops = '0, req1_ops = '0;
    logic              rsp0_valid, rsp1_valid;
    logic              rsp0_ready = 1'b0, rsp1_ready = 1'b0;
    logic [DATA_W-1:0] rsp0_data, rsp1_data;
    logic [DATA_W-1:0] alu_a, alu_b, alu_out;
    logic [OPS_W-1:0]  alu_ops;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [DATA_W-1:0] q0[$];
    logic [DATA_W-1:0] q1[$];
    int                m_last;   // requester granted most recently

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] alu_ref(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                                                  input logic [OPS_W-1:0] op);
        case (op)
            ADD_OP:  return a + b;
            SUB_OP:  return a - b;
            AND_OP:  return a & b;
            OR_OP:   return a | b;
            XOR_OP:  return a ^ b;
            BEQ_OP:  return (a == b) ? 32'd1 : 32'd0;
            BNE_OP:  return (a != b) ? 32'd1 : 32'd0;
            default: return '0;
        endcase
    endfunction

    // Shared combinational ALU
    assign alu_out = alu_ref(alu_a, alu_b, alu_ops);

    alu_arbiter #(.DATA_W(DATA_W), .OPS_W(OPS_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_ops   (req0_ops),
        .rsp0_valid (rsp0_valid),
        .rsp0_ready (rsp0_ready),
        .rsp0_data  (rsp0_data),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_ops   (req1_ops),
        .rsp1_valid (rsp1_valid),
        .rsp1_ready (rsp1_ready),
        .rsp1_data  (rsp1_data),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_ops    (alu_ops),
        .alu_out    (alu_out)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive at negedge, check settled outputs against the model, then advance the model.
    task automatic cycle(input logic v0, input logic [31:0] a0, input logic [31:0] b0, input logic [6:0] o0,
                         input logic r0,
                         input logic v1, input logic [31:0] a1, input logic [31:0] b1, input logic [6:0] o1,
                         input logic r1);
        bit el0, el1, g0, g1;
        @(negedge clk);
        req0_valid = v0; req0_a = a0; req0_b = b0; req0_ops = o0; rsp0_ready = r0;
        req1_valid = v1; req1_a = a1; req1_b = b1; req1_ops = o1; rsp1_ready = r1;
        #1;
        el0 = v0 && (q0.size() < 2 || r0);
        el1 = v1 && (q1.size() < 2 || r1);
        g0  = el0 && (!el1 || m_last == 1);
        g1  = el1 && (!el0 || m_last == 0);
        chk("req0_ready", req0_ready, g0);
        chk("req1_ready", req1_ready, g1);
        chk("rsp0_valid", rsp0_valid, q0.size() != 0);
        chk("rsp1_valid", rsp1_valid, q1.size() != 0);
        if (q0.size() != 0) chk("rsp0_data", rsp0_data, q0[0]);
        if (q1.size() != 0) chk("rsp1_data", rsp1_data, q1[0]);
        if (g0) begin
            chk("alu_a", alu_a, a0);
            chk("alu_ops", alu_ops, o0);
        end else if (g1) begin
            chk("alu_b", alu_b, b1);
            chk("alu_ops", alu_ops, o1);
        end else begin
            chk("alu_idle", {alu_a[15:0], alu_b[8:0], alu_ops}, 32'd0);
        end
        if (q0.size() != 0 && r0) void'(q0.pop_front());
        if (q1.size() != 0 && r1) void'(q1.pop_front());
        if (g0) begin q0.push_back(alu_ref(a0, b0, o0)); m_last = 0; end
        if (g1) begin q1.push_back(alu_ref(a1, b1, o1)); m_last = 1; end
    endtask

    task automatic idle(input logic r0, input logic r1);
        cycle(0, 0, 0, 0, r0, 0, 0, 0, 0, r1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1; rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        #1;
        chk("rst_req0_ready", req0_ready, 0);
        chk("rst_req1_ready", req1_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0; rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        #1;
        chk("rst_rsp0_valid", rsp0_valid, 0);
        chk("rst_rsp1_valid", rsp1_valid, 0);
        q0.delete();
        q1.delete();
        m_last = 1;
    endtask

    initial begin
        m_last = 1;
        do_reset();

        // Single op on requester 0
        cycle(1, 5, 3, ADD_OP, 0, 0, 0, 0, 0, 0);
        idle(0, 0);
        chk("single_rsp0_data", rsp0_data, 8);
        chk("single_rsp1_valid", rsp1_valid, 0);
        idle(1, 0);
        idle(0, 0);

        // Conflict: alternate 0,1,0,1 from reset
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cycle(1, 10, 4, SUB_OP, 1, 1, 32'hF0F0, 32'h0FF0, XOR_OP, 1);
            chk("conflict_grant0", req0_ready, (i % 2 == 0) ? 1 : 0);
            if (i == 1) chk("conflict_r0", rsp0_data, 6);
            if (i == 2) chk("conflict_r1", rsp1_data, 32'hFF00);
        end
        idle(1, 1);
        idle(1, 1);

        // Backpressure on requester 1
        cycle(0, 0, 0, 0, 0, 1, 1, 1, ADD_OP, 0);
        cycle(0, 0, 0, 0, 0, 1, 2, 2, ADD_OP, 0);
        cycle(0, 0, 0, 0, 0, 1, 3, 3, ADD_OP, 0);
        chk("bp_stall", req1_ready, 0);
        chk("bp_head", rsp1_data, 2);
        cycle(0, 0, 0, 0, 0, 1, 3, 3, ADD_OP, 1);
        chk("bp_poppush", req1_ready, 1);
        idle(0, 0);
        chk("bp_second", rsp1_data, 4);
        idle(0, 1);
        idle(0, 1);
        chk("bp_third", rsp1_data, 6);
        idle(0, 1);

        // Isolation: rsp0 full and blocked, req1 streams
        cycle(1, 1, 1, ADD_OP, 0, 0, 0, 0, 0, 1);
        cycle(1, 2, 2, ADD_OP, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 6; i++) begin
            cycle(1, 9, 9, ADD_OP, 0, 1, 32'hFF00 + i, 32'h0F0F, AND_OP, 1);
            chk("iso_req1_ready", req1_ready, 1);
        end
        idle(1, 1);
        idle(1, 1);
        idle(1, 1);

        // Compare ops
        cycle(1, 7, 7, BNE_OP, 1, 0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 1, 1, 7, 7, BEQ_OP, 1);
        chk("bne_result", rsp0_data, 0);
        chk("bne_valid", rsp0_valid, 1);
        idle(1, 1);
        chk("beq_result", rsp1_data, 1);

        // Reset mid-stream with both FIFOs full
        for (int i = 0; i < 4; i++) cycle(1, i, 1, ADD_OP, 0, 1, i, 2, OR_OP, 0);
        chk("full0_before_rst", rsp0_valid, 1);
        do_reset();
        cycle(1, 20, 1, SUB_OP, 1, 1, 20, 2, SUB_OP, 1);
        chk("post_rst_grant0", req0_ready, 1);
        chk("post_rst_grant1", req1_ready, 0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 3) != 0, $urandom, $urandom, 7'($urandom_range(0, 9)), $urandom_range(0, 2) != 0,
                  $urandom_range(0, 3) != 0, $urandom, $urandom, 7'($urandom_range(0, 9)), $urandom_range(0, 2) != 0);
        end
        for (int i = 0; i < 3; i++) idle(1, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
